uart_tx_sequencer: RTL

- Message-level driver for the write side of the UART transmitter handshake (Tx_DATA / Tx_WR / Tx_EN / Tx_BUSY).
- Latches a multi-byte word on a start pulse and feeds it to the transmitter one byte at a time, MSB byte first.
- Waits out each byte's busy window and inserts a programmable idle gap between bytes.
- Sits between user/LED control logic and the uart_transmitter inside the UART top level.

---
 rtl/uart_tx_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// Purpose: sends a latched 8*NUM_BYTES word to the UART transmitter one byte at a time, MSB byte first.
// Latency: first Tx_WR 2 cycles after start (Tx_BUSY low); GAP_CYCLES+2 cycles from each Tx_BUSY fall to the next Tx_WR.
// Backpressure: holds in LOAD while Tx_BUSY is high; aborts with sticky seq_error if Tx_BUSY does not rise within BUSY_TIMEOUT.
// Optional: define UART_SEQ_CHECKSUM_EN to append an XOR-of-all-bytes checksum byte to every message.
module uart_tx_sequencer #(
  parameter int NUM_BYTES    = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] msg_word,
  input  logic                   Tx_BUSY,
  output logic [7:0]             Tx_DATA,
  output logic                   Tx_WR,
  output logic                   Tx_EN,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   seq_error
);

`ifdef UART_SEQ_CHECKSUM_EN
  localparam int TOTAL_BYTES = NUM_BYTES + 1;
`else
  localparam int TOTAL_BYTES = NUM_BYTES;
`endif
  localparam int SR_W  = 8 * TOTAL_BYTES;
  localparam int IDX_W = $clog2(TOTAL_BYTES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam int TO_W  = $clog2(BUSY_TIMEOUT) + 1;

  // Terminal counts: each counter stops at its last value, so none can wrap.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [SR_W-1:0]    shreg, shreg_nxt;
  logic [SR_W-1:0]    start_image;
  logic [IDX_W-1:0]   byte_idx, byte_idx_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic               seq_error_nxt;
  logic [7:0]         tx_data_nxt;

`ifdef UART_SEQ_CHECKSUM_EN
  logic [7:0] msg_xor;

  // Fold every message byte into one XOR byte; it rides at the bottom of the shift register.
  always_comb begin
    msg_xor = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      msg_xor = msg_xor ^ msg_word[8*i +: 8];
    end
  end

  assign start_image = {msg_word, msg_xor};
`else
  assign start_image = msg_word;
`endif

  // Next-state and datapath decisions for the byte sequencer.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    byte_idx_nxt  = byte_idx;
    gap_cnt_nxt   = gap_cnt;
    to_cnt_nxt    = to_cnt;
    seq_error_nxt = seq_error;
    tx_data_nxt   = Tx_DATA;

    case (state)
      S_IDLE: begin
        if (start) begin
          shreg_nxt     = start_image;
          byte_idx_nxt  = '0;
          seq_error_nxt = 1'b0;
          state_nxt     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!Tx_BUSY) begin
          state_nxt = S_WRITE;
        end
      end

      S_WRITE: begin
        to_cnt_nxt = '0;
        state_nxt  = S_WAIT_HI;
      end

      S_WAIT_HI: begin
        if (Tx_BUSY) begin
          state_nxt = S_WAIT_LO;
        end else if (to_cnt == TO_LAST) begin
          // Transmitter never acknowledged the write: give up on the whole message.
          seq_error_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end

      S_WAIT_LO: begin
        if (!Tx_BUSY) begin
          shreg_nxt    = shreg << 8;
          byte_idx_nxt = byte_idx + 1'b1;
          if (byte_idx == IDX_LAST) begin
            state_nxt = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            state_nxt = S_LOAD;
          end else begin
            gap_cnt_nxt = '0;
            state_nxt   = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_LOAD;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // The byte is captured on entry to LOAD so it is already valid during LOAD
    // and stays untouched through WRITE and both WAIT states.
    if ((state_nxt == S_LOAD) && (state != S_LOAD)) begin
      tx_data_nxt = shreg_nxt[SR_W-1 -: 8];
    end
  end

  // State, counters, shift register and registered byte output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      seq_error <= 1'b0;
      Tx_DATA   <= 8'h00;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      byte_idx  <= byte_idx_nxt;
      gap_cnt   <= gap_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      seq_error <= seq_error_nxt;
      Tx_DATA   <= tx_data_nxt;
    end
  end

  // Strobes and status are pure decodes of the registered state, so an
  // asynchronous reset forces them low immediately.
  assign Tx_WR    = (state == S_WRITE);
  assign Tx_EN    = (state != S_IDLE);
  assign seq_busy = (state != S_IDLE);
  assign seq_done = (state == S_DONE);

endmodule
